anemo_measure_ctrl: RTL and testbench
=====================================

Name: anemo_measure_ctrl

Overview:
Measurement sequencer for the anemometer path. It takes the raw anemometer pulse input and counts rising edges over a fixed gate window. A small Avalon-MM slave register file holds the run controls (continu, start_stop, raz). The block drives the single-shot, continuous and clear sequencing, and presents the latched result and status to the Nios software.

Parameters:
GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); minimum 4.
CNT_WIDTH, 8, width of the pulse counter and of the result.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_freq_anemometre  in  1  raw anemometer pulse, asynchronous to clk
address  in  2  Avalon register select
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
data_valid  out  1  result register holds a completed measurement
data_anemometre  out  CNT_WIDTH  last latched result

Behaviour:
- Reset: clk rising edge; reset_n is asynchronous, active-low.
- On reset, all of these are 0: readdata, data_valid, data_anemometre, control bits, counters and synchroniser. State = IDLE.
- Register map:
  - addr0 CTRL (R/W): bit0 continu, bit1 start_stop, bit2 raz. raz self-clears the cycle after the write and always reads 0.
  - addr1 STATUS (RO): bit0 data_valid, bit1 busy (state = MEASURE).
  - addr2 DATA (RO): zero-extended data_anemometre.
  - addr3 reads 0; writes to addr1..3 are ignored.
- Write: occurs when chipselect=1 and write_n=0; it takes effect at that clk edge.
- Read: readdata is updated every cycle from the mux of address, with 1 clk latency; chipselect is not required for reads.
- Input conditioning: 2-FF synchroniser, then an edge register. A rising edge is detected 3 clk after the input rises.
- Pulse counter: saturates at 2^CNT_WIDTH-1, never wraps.
- Gate counter: runs 0..GATE_CYCLES-1.
- FSM states: IDLE, MEASURE, LATCH.
  - IDLE -> MEASURE when continu=1, or on a 0->1 transition of the start_stop register bit.
    - Entering MEASURE clears both counters.
    - A single-shot start (continu=0) also clears data_valid.
  - MEASURE: counts detected edges every cycle. When gate count = GATE_CYCLES-1, go to LATCH; an edge detected in that final cycle is included.
  - LATCH (1 cycle): data_anemometre <= pulse count, data_valid <= 1.
    - Then, if continu=1: go to MEASURE, counters cleared. Consecutive windows are spaced by exactly GATE_CYCLES+1 clk.
    - Else: go to IDLE.
- start_stop edges while in MEASURE or LATCH are ignored; the edge is not queued.
- Clearing continu mid-window: the current window completes and latches, then the FSM returns to IDLE.
- raz has highest priority, in any state, in the same cycle it is written:
  - FSM goes to IDLE.
  - Counters, data_anemometre and data_valid are cleared.
  - continu and start_stop keep the values written in the same CTRL write.
  - No latch occurs even if the gate terminal count coincides.
- Continuous mode: data_valid stays 1 after the first window and DATA updates each LATCH.
- Single-shot mode: data_valid stays 1 until the next single-shot start or raz.
- Edges occurring while in IDLE or LATCH are discarded.
- Asserting reset_n low mid-measurement aborts immediately to reset values; no partial result is kept.

Test Plan:
1. Reset with GATE_CYCLES=100, then read addr0/1/2 -> readdata 0 one clk after each address; data_valid=0.
2. Single shot: write CTRL=0x2, then drive 7 pulses (5 clk high / 5 low) inside the window -> busy=1 for 100 clk. Then data_anemometre=7, data_valid=1, STATUS=0x1, DATA read=7.
3. Saturation: GATE_CYCLES=2000, CNT_WIDTH=8, 300 pulses in one single shot -> DATA=255, no wrap.
4. Continuous: write CTRL=0x1, drive 3 pulses in window 1 and 5 in window 2 -> DATA=3, then 5. data_valid stays 1; LATCH events 101 clk apart.
5. Write raz (CTRL=0x4) at cycle 50 of a window with 4 pulses already counted -> DATA=0, data_valid=0, busy=0; CTRL reads 0 next cycle; no latch at cycle 100.
6. Write start_stop=1 again mid-window (0->1 via an intermediate 0) -> ignored. Clear continu mid-window -> the window still latches its count, then busy=0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/anemo_measure_ctrl.sv
// Anemometer measurement sequencer: gated pulse counter with an
// Avalon-MM control/status register file.
module anemo_measure_ctrl #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_freq_anemometre,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 data_valid,
  output logic [CNT_WIDTH-1:0] data_anemometre
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LATCH
  } state_e;

  state_e               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic                 continu_q;
  logic                 start_stop_q;
  logic                 ss_prev_q;
  logic [CNT_WIDTH-1:0] pulse_q;
  logic [CNT_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic [GW-1:0]        gate_q;
  logic [31:0]          rdata_q;

  logic                 ctrl_wr;
  logic                 raz;
  logic                 edge_det;
  logic                 start_rise;
  logic                 busy;
  logic [CNT_WIDTH-1:0] pulse_inc;
  logic                 unused_wdata;

  assign ctrl_wr    = chipselect & ~write_n & (address == 2'd0);
  assign raz        = ctrl_wr & writedata[2];
  assign edge_det   = sync2_q & ~prev_q;
  assign start_rise = start_stop_q & ~ss_prev_q;
  assign busy       = (state_q == MEASURE);
  assign pulse_inc  = (pulse_q == CNT_MAX) ? pulse_q : pulse_q + 1'b1;
  assign unused_wdata = ^writedata[31:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in_freq_anemometre;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // ss_prev_q follows every cycle so a rise seen outside IDLE is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      continu_q    <= 1'b0;
      start_stop_q <= 1'b0;
      ss_prev_q    <= 1'b0;
    end else begin
      ss_prev_q <= start_stop_q;
      if (ctrl_wr) begin
        continu_q    <= writedata[0];
        start_stop_q <= writedata[1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pulse_q <= '0;
      gate_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (raz) begin
      state_q <= IDLE;
      pulse_q <= '0;
      gate_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (continu_q || start_rise) begin
            state_q <= MEASURE;
            pulse_q <= '0;
            gate_q  <= '0;
            if (!continu_q) valid_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) pulse_q <= pulse_inc;
          if (gate_q == GATE_LAST) state_q <= LATCH;
          else gate_q <= gate_q + 1'b1;
        end
        LATCH: begin
          data_q  <= pulse_q;
          valid_q <= 1'b1;
          pulse_q <= '0;
          gate_q  <= '0;
          state_q <= continu_q ? MEASURE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      unique case (address)
        2'd0:    rdata_q <= {30'd0, start_stop_q, continu_q};
        2'd1:    rdata_q <= {30'd0, busy, valid_q};
        2'd2:    rdata_q <= 32'(data_q);
        default: rdata_q <= '0;
      endcase
    end
  end

  assign readdata        = rdata_q;
  assign data_valid      = valid_q;
  assign data_anemometre = data_q;

endmodule

// File: tb/tb_anemo_measure_ctrl.sv
// Directed bench for anemo_measure_ctrl: single shot, saturation,
// continuous, raz, ignored restarts and reset abort.
module tb_anemo_measure_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pulse_a = 1'b0;
  logic        pulse_b = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata_a, readdata_b;
  logic        valid_a, valid_b;
  logic [7:0]  data_a, data_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  anemo_measure_ctrl #(.GATE_CYCLES(100), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_freq_anemometre(pulse_a),
    .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(readdata_a),
    .data_valid(valid_a), .data_anemometre(data_a)
  );

  anemo_measure_ctrl #(.GATE_CYCLES(2000), .CNT_WIDTH(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_freq_anemometre(pulse_b),
    .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(readdata_b),
    .data_valid(valid_b), .data_anemometre(data_b)
  );

  // busy observer on dut: STATUS bit1 seen while address was 1
  logic [1:0] last_addr = 2'd0;
  bit         mon_en = 1'b0;
  bit         pb = 1'b0;
  int         cyc = 0;
  int         b_first = -1;
  int         b_last = -1;
  int         n_fall = 0;
  int         vdrop = 0;
  int         fall_t[4];

  always @(posedge clk) last_addr <= address;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (!valid_a) vdrop++;
      if (last_addr == 2'd1) begin
        if (readdata_a[1]) begin
          if (b_first < 0) b_first = cyc;
          b_last = cyc;
        end else if (pb) begin
          if (n_fall < 4) fall_t[n_fall] = cyc;
          n_fall++;
        end
        pb = readdata_a[1];
      end else begin
        pb = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [1:0] sel = 2'b01);
    address   = a;
    writedata = d;
    cs_a      = sel[0];
    cs_b      = sel[1];
    write_n   = 1'b0;
    tick();
    cs_a      = 1'b0;
    cs_b      = 1'b0;
    write_n   = 1'b1;
    address   = 2'd1;
  endtask

  task automatic pulses(input bit which, input int n, input int hi,
                        input int lo);
    for (int i = 0; i < n; i++) begin
      if (which) pulse_b = 1'b1; else pulse_a = 1'b1;
      tick(hi);
      if (which) pulse_b = 1'b0; else pulse_a = 1'b0;
      tick(lo);
    end
  endtask

  task automatic mon_clear();
    b_first = -1;
    b_last  = -1;
    n_fall  = 0;
    vdrop   = 0;
    pb      = 1'b0;
    mon_en  = 1'b1;
  endtask

  initial begin
    // 1: reset state and register reads
    tick(3);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) begin
      address = 2'(a);
      tick();
      check($sformatf("rst_rd%0d", a), readdata_a, 32'd0);
    end
    check("rst_valid2", 32'(valid_a), 32'd0);

    // 2: single shot, 7 pulses, busy for 100 clk
    address = 2'd1;
    mon_clear();
    wr(2'd0, 32'h2);
    pulses(1'b0, 7, 5, 5);
    tick(40);
    check("ss_busy_len", 32'(b_last - b_first + 1), 32'd100);
    check("ss_data", 32'(data_a), 32'd7);
    check("ss_valid", 32'(valid_a), 32'd1);
    check("ss_status", readdata_a, 32'h1);
    address = 2'd2;
    tick();
    check("ss_rd_data", readdata_a, 32'd7);

    // 3: saturation on the 2000-cycle instance
    wr(2'd0, 32'h2, 2'b10);
    pulses(1'b1, 300, 2, 2);
    tick(850);
    check("sat_data", 32'(data_b), 32'd255);
    check("sat_valid", 32'(valid_b), 32'd1);
    check("sat_status", readdata_b, 32'h1);
    check("sat_other_data", 32'(data_a), 32'd7);

    // 4: continuous, 3 then 5 pulses
    mon_clear();
    wr(2'd0, 32'h1);
    pulses(1'b0, 3, 5, 5);
    tick(75);
    check("cont_w1", 32'(data_a), 32'd3);
    tick(5);
    pulses(1'b0, 5, 5, 5);
    tick(45);
    check("cont_w2", 32'(data_a), 32'd5);
    check("cont_nfall", 32'(n_fall >= 2), 32'd1);
    check("cont_spacing", 32'(fall_t[1] - fall_t[0]), 32'd101);
    check("cont_vdrop", 32'(vdrop), 32'd0);

    // 5: raz mid-window
    wr(2'd0, 32'h5);
    check("raz0_data", 32'(data_a), 32'd0);
    check("raz0_valid", 32'(valid_a), 32'd0);
    pulses(1'b0, 4, 5, 5);
    tick(9);
    wr(2'd0, 32'h4);
    check("raz_data", 32'(data_a), 32'd0);
    check("raz_valid", 32'(valid_a), 32'd0);
    address = 2'd0;
    tick();
    check("raz_ctrl_rd", readdata_a, 32'd0);
    address = 2'd1;
    tick();
    check("raz_status", readdata_a, 32'd0);
    mon_clear();
    tick(60);
    check("raz_no_busy", 32'(b_first < 0), 32'd1);
    check("raz_no_latch_v", 32'(valid_a), 32'd0);
    check("raz_no_latch_d", 32'(data_a), 32'd0);

    // 6a: start_stop re-rise mid-window is ignored
    mon_clear();
    wr(2'd0, 32'h2);
    pulses(1'b0, 2, 5, 5);
    tick(10);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h2);
    tick(78);
    check("rerise_data", 32'(data_a), 32'd2);
    check("rerise_valid", 32'(valid_a), 32'd1);
    tick(60);
    check("rerise_busy_len", 32'(b_last - b_first + 1), 32'd100);

    // 6b: continu cleared mid-window still latches, then idles
    mon_clear();
    wr(2'd0, 32'h1);
    pulses(1'b0, 3, 5, 5);
    tick(30);
    wr(2'd0, 32'h0);
    tick(49);
    check("cstop_data", 32'(data_a), 32'd3);
    check("cstop_valid", 32'(valid_a), 32'd1);
    tick(140);
    check("cstop_busy_len", 32'(b_last - b_first + 1), 32'd100);
    check("cstop_data2", 32'(data_a), 32'd3);
    check("cstop_status", readdata_a, 32'h1);

    // 7: reset mid-measurement drops everything
    mon_en = 1'b0;
    wr(2'd0, 32'h2);
    pulses(1'b0, 3, 5, 5);
    reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_data", 32'(data_a), 32'd0);
    check("abort_rd", readdata_a, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(120);
    check("abort_no_latch", 32'(valid_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
